// File: rtl/enc_4to2_seq_pkg.sv
// Shared types and widths for the sequential 4-to-2 encoder and its helpers.
package enc_pkg;

  localparam int ENC_W  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/enc_4to2_seq_if.sv
// Request/handshake bundle between a request collector (master) and the encoder (slave).
interface enc_4to2_seq_if;
  import enc_pkg::*;

  logic [ENC_W-1:0]  req_in;
  logic              load_in;
  logic              ready_in;
  logic [CODE_W-1:0] code_out;
  logic              valid_out;
  logic              busy_out;
  logic              done_out;

  modport master (
    output req_in, load_in, ready_in,
    input  code_out, valid_out, busy_out, done_out
  );

  modport slave (
    input  req_in, load_in, ready_in,
    output code_out, valid_out, busy_out, done_out
  );

endinterface

// File: rtl/enc_4to2_seq_pick_first.sv
// Finds the first set bit of vec at or after index start, wrapping from the top back to 0.
module pick_first
  import enc_pkg::*;
(
  input  logic [ENC_W-1:0]  vec,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] code
);

  logic              found_s;
  logic [CODE_W-1:0] idx_s;

  // Wrapping scan; the first hit wins and later hits are masked by found_s.
  always_comb begin
    code    = {CODE_W{1'b0}};
    found_s = 1'b0;
    idx_s   = {CODE_W{1'b0}};
    for (int i = 0; i < ENC_W; i++) begin
      idx_s   = start + CODE_W'(i);
      code    = (!found_s && vec[idx_s]) ? idx_s : code;
      found_s = found_s | vec[idx_s];
    end
  end

endmodule

// File: rtl/enc_4to2_seq.sv
// Sequential 4-to-2 encoder: captures a request vector and hands out one set-bit index per handshake.
module enc_4to2_seq
  import enc_pkg::*;
#(
  parameter bit RR_EN = 1'b0
)(
  input  logic          clk_in,
  input  logic          rst_n_in,
  enc_4to2_seq_if.slave bus
);

  state_e            state_r, state_nxt_s;
  logic [ENC_W-1:0]  pending_r, pending_nxt_s;
  logic [CODE_W-1:0] rr_r, rr_nxt_s;
  logic [CODE_W-1:0] code_r, code_nxt_s;
  logic              valid_r, busy_r, done_r, done_nxt_s;
  logic [ENC_W-1:0]  emit_mask_s;
  logic [CODE_W-1:0] pick_start_s, pick_code_s;

  assign emit_mask_s  = {{(ENC_W-1){1'b0}}, 1'b1} << code_r;
  // The offered code is precomputed from next-state so code_out can come straight from a flop.
  assign pick_start_s = RR_EN ? rr_nxt_s : {CODE_W{1'b0}};

  pick_first u_pick (
    .vec   (pending_nxt_s),
    .start (pick_start_s),
    .code  (pick_code_s)
  );

  // Next-state, pending/pointer update and done pulse generation.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    rr_nxt_s      = rr_r;
    done_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.load_in) begin
          if (bus.req_in != {ENC_W{1'b0}}) begin
            pending_nxt_s = bus.req_in;
            state_nxt_s   = EMIT;
          end else begin
            done_nxt_s = 1'b1;
          end
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      EMIT: begin
        if (bus.ready_in) begin
          pending_nxt_s = pending_r & ~emit_mask_s;
          rr_nxt_s      = RR_EN ? (code_r + {{(CODE_W-1){1'b0}}, 1'b1}) : rr_r;
          if (pending_nxt_s == {ENC_W{1'b0}}) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = EMIT;
          end
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = {ENC_W{1'b0}};
      end
    endcase
    code_nxt_s = (state_nxt_s == EMIT) ? pick_code_s : {CODE_W{1'b0}};
  end

  // State and registered outputs; synchronous active-low reset discards everything.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r   <= IDLE;
      pending_r <= {ENC_W{1'b0}};
      rr_r      <= {CODE_W{1'b0}};
      code_r    <= {CODE_W{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      rr_r      <= rr_nxt_s;
      code_r    <= code_nxt_s;
      valid_r   <= (state_nxt_s == EMIT);
      busy_r    <= (state_nxt_s == EMIT);
      done_r    <= done_nxt_s;
    end
  end

  assign bus.code_out  = code_r;
  assign bus.valid_out = valid_r;
  assign bus.busy_out  = busy_r;
  assign bus.done_out  = done_r;

endmodule

// File: tb/tb_enc_4to2_seq.sv
// Directed bench: fixed-priority and round-robin encoder instances against hand-computed vectors.
module tb_enc_4to2_seq;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk_in = ~clk_in;

  enc_4to2_seq_if if_fp ();
  enc_4to2_seq_if if_rr ();

  enc_4to2_seq #(.RR_EN(1'b0)) dut_fp (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if_fp));
  enc_4to2_seq #(.RR_EN(1'b1)) dut_rr (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if_rr));

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Checks code/valid/busy/done of the fixed-priority instance in one go.
  task automatic chk_fp(input string tag, input logic [1:0] c, input logic v, input logic b, input logic d);
    check_eq({tag, ".code"},  {2'b00, if_fp.code_out}, {2'b00, c});
    check_eq({tag, ".valid"}, {3'b000, if_fp.valid_out}, {3'b000, v});
    check_eq({tag, ".busy"},  {3'b000, if_fp.busy_out}, {3'b000, b});
    check_eq({tag, ".done"},  {3'b000, if_fp.done_out}, {3'b000, d});
  endtask

  task automatic chk_rr(input string tag, input logic [1:0] c, input logic v, input logic d);
    check_eq({tag, ".code"},  {2'b00, if_rr.code_out}, {2'b00, c});
    check_eq({tag, ".valid"}, {3'b000, if_rr.valid_out}, {3'b000, v});
    check_eq({tag, ".done"},  {3'b000, if_rr.done_out}, {3'b000, d});
  endtask

  initial begin
    if_fp.req_in = 4'b0000; if_fp.load_in = 1'b0; if_fp.ready_in = 1'b0;
    if_rr.req_in = 4'b0000; if_rr.load_in = 1'b0; if_rr.ready_in = 1'b0;
    tick(); tick();
    chk_fp("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    chk_rr("reset_rr", 2'd0, 1'b0, 1'b0);
    rst_n_in = 1'b1;

    // Fixed priority, ready high: 1011 -> 0, 1, 3 then done.
    if_fp.ready_in = 1'b1; if_fp.load_in = 1'b1; if_fp.req_in = 4'b1011;
    tick(); if_fp.load_in = 1'b0;
    chk_fp("fp_c0", 2'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk_fp("fp_c1", 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); chk_fp("fp_c3", 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); chk_fp("fp_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk_fp("fp_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Stall: 0100 held for five cycles with ready low.
    if_fp.ready_in = 1'b0; if_fp.load_in = 1'b1; if_fp.req_in = 4'b0100;
    tick(); if_fp.load_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_fp($sformatf("stall%0d", i), 2'd2, 1'b1, 1'b1, 1'b0);
      if (i < 4) tick();
    end
    if_fp.ready_in = 1'b1;
    tick(); chk_fp("stall_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk_fp("stall_after", 2'd0, 1'b0, 1'b0, 1'b0);

    // Empty load: done pulse only.
    if_fp.load_in = 1'b1; if_fp.req_in = 4'b0000;
    tick(); if_fp.load_in = 1'b0;
    chk_fp("empty_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk_fp("empty_after", 2'd0, 1'b0, 1'b0, 1'b0);

    // Load during EMIT is ignored.
    if_fp.ready_in = 1'b0; if_fp.load_in = 1'b1; if_fp.req_in = 4'b1000;
    tick(); chk_fp("ign_c3", 2'd3, 1'b1, 1'b1, 1'b0);
    if_fp.req_in = 4'b0001;
    tick(); chk_fp("ign_hold", 2'd3, 1'b1, 1'b1, 1'b0);
    if_fp.load_in = 1'b0; if_fp.ready_in = 1'b1;
    tick(); chk_fp("ign_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk_fp("ign_after", 2'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: load accepted in the done_out cycle.
    if_fp.load_in = 1'b1; if_fp.req_in = 4'b0100;
    tick(); if_fp.load_in = 1'b0;
    chk_fp("b2b_c2", 2'd2, 1'b1, 1'b1, 1'b0);
    tick(); chk_fp("b2b_done1", 2'd0, 1'b0, 1'b0, 1'b1);
    if_fp.load_in = 1'b1; if_fp.req_in = 4'b0010;
    tick(); if_fp.load_in = 1'b0;
    chk_fp("b2b_c1", 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); chk_fp("b2b_done2", 2'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset mid-EMIT: no done pulse afterwards.
    if_fp.load_in = 1'b1; if_fp.req_in = 4'b1111;
    tick(); if_fp.load_in = 1'b0;
    chk_fp("rst_c0", 2'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk_fp("rst_c1", 2'd1, 1'b1, 1'b1, 1'b0);
    rst_n_in = 1'b0;
    tick(); chk_fp("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n_in = 1'b1;
    tick(); chk_fp("rst_nodone", 2'd0, 1'b0, 1'b0, 1'b0);

    // Round-robin: 0011 -> 0,1; 1001 -> 3,0 (wrap); 0011 -> 1,0.
    if_rr.ready_in = 1'b1; if_rr.load_in = 1'b1; if_rr.req_in = 4'b0011;
    tick(); if_rr.load_in = 1'b0;
    chk_rr("rr_a0", 2'd0, 1'b1, 1'b0);
    tick(); chk_rr("rr_a1", 2'd1, 1'b1, 1'b0);
    tick(); chk_rr("rr_adone", 2'd0, 1'b0, 1'b1);
    if_rr.load_in = 1'b1; if_rr.req_in = 4'b1001;
    tick(); if_rr.load_in = 1'b0;
    chk_rr("rr_b3", 2'd3, 1'b1, 1'b0);
    tick(); chk_rr("rr_b0", 2'd0, 1'b1, 1'b0);
    tick(); chk_rr("rr_bdone", 2'd0, 1'b0, 1'b1);
    if_rr.load_in = 1'b1; if_rr.req_in = 4'b0011;
    tick(); if_rr.load_in = 1'b0;
    chk_rr("rr_c1", 2'd1, 1'b1, 1'b0);
    tick(); chk_rr("rr_c0", 2'd0, 1'b1, 1'b0);
    tick(); chk_rr("rr_cdone", 2'd0, 1'b0, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
